// File: rtl/sim_match_pkg.sv
// Shared definitions for the similarity-match datapath: score width and search FSM states.
// Used by score_argmax and by the upstream score producer.
package sim_match_pkg;

  localparam int SCORE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic state_busy(input state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/window_accum.sv
// Window accumulator: sums WIN_LEN qualified scores and flags the cycle that takes the last one.
// clr has priority over act; the sample counter wraps to 0 on the last accepted score.
module window_accum
  import sim_match_pkg::*;
#(
  parameter  int WIN_LEN = 8,
  localparam int ACC_W   = SCORE_W + $clog2(WIN_LEN),
  localparam int CNT_W   = $clog2(WIN_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               act,
  input  logic [SCORE_W-1:0] score,
  output logic [ACC_W-1:0]   sum,
  output logic               last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = act && (r_cnt == LAST_CNT);

  // WIN_LEN*255 always fits in ACC_W, so the add never needs saturation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (act) begin
      r_sum <= r_sum + ACC_W'(score);
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign sum  = r_sum;
  assign last = w_last;

endmodule

// File: rtl/score_argmax.sv
// Arg-max search over NUM_CAND windowed score sums; reports the lowest-index best candidate.
// Optional feature MATCH_THRESH_EN adds min_sum / match_ok threshold reporting.
module score_argmax
  import sim_match_pkg::*;
#(
  parameter  int WIN_LEN  = 8,
  parameter  int NUM_CAND = 16,
  localparam int ACC_W    = SCORE_W + $clog2(WIN_LEN),
  localparam int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               act,
  input  logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   best_idx,
  output logic [ACC_W-1:0]   best_sum,
  output logic [1:0]         o_dbg_state
`ifdef MATCH_THRESH_EN
  ,
  input  logic [ACC_W-1:0]   min_sum,
  output logic               match_ok
`endif
);

  localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NUM_CAND - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_cand;
  logic [IDX_W-1:0] r_best_idx;
  logic [ACC_W-1:0] r_best_sum;

  logic             w_acc_clr;
  logic             w_acc_act;
  logic [ACC_W-1:0] w_sum;
  logic             w_last;

  // act is a valid-only qualifier (no ready): score is consumed on every ACCUM
  // cycle with act=1, and dropped in any other state, including COMPARE.
  window_accum #(
    .WIN_LEN (WIN_LEN)
  ) u_window_accum (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_acc_clr),
    .act   (w_acc_act),
    .score (score),
    .sum   (w_sum),
    .last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = ACCUM;
      ACCUM:   if (w_last) w_next_state = COMPARE;
      COMPARE: w_next_state = (r_cand == LAST_CAND) ? DONE : ACCUM;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = state_busy(r_state);
    done      = (r_state == DONE);
    w_acc_act = (r_state == ACCUM) && act;
    w_acc_clr = ((r_state == IDLE) && start) || (r_state == COMPARE);
  end

  // Strict greater-than keeps the earliest candidate on ties; candidate 0 always loads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cand     <= '0;
      r_best_idx <= '0;
      r_best_sum <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cand     <= '0;
            r_best_idx <= '0;
            r_best_sum <= '0;
          end
        end
        COMPARE: begin
          if ((r_cand == '0) || (w_sum > r_best_sum)) begin
            r_best_sum <= w_sum;
            r_best_idx <= r_cand;
          end
          if (r_cand != LAST_CAND) begin
            r_cand <= r_cand + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign best_idx    = r_best_idx;
  assign best_sum    = r_best_sum;
  assign o_dbg_state = r_state;

`ifdef MATCH_THRESH_EN
  logic r_match_ok;

  // best_sum is already final in DONE, so the threshold is evaluated there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_match_ok <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_match_ok <= 1'b0;
    end else if (r_state == DONE) begin
      r_match_ok <= (r_best_sum >= min_sum);
    end
  end

  assign match_ok = r_match_ok;
`endif

endmodule

// File: tb/tb_score_argmax.sv
// Directed bench for score_argmax: hand-computed arg-max results, done latency, reset abort.
// Build with MATCH_THRESH_EN defined to also exercise the threshold ports.
module tb_score_argmax;

  localparam int WIN_LEN  = 8;
  localparam int NUM_CAND = 16;
  localparam int ACC_W    = 11;
  localparam int IDX_W    = 4;

  // clock / reset
  logic clk;
  logic rst;
  logic start;
  logic act;
  logic [7:0] score;
  logic busy;
  logic done;
  logic [IDX_W-1:0] best_idx;
  logic [ACC_W-1:0] best_sum;
  logic [1:0] o_dbg_state;
`ifdef MATCH_THRESH_EN
  logic [ACC_W-1:0] min_sum;
  logic match_ok;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  score_argmax #(
    .WIN_LEN  (WIN_LEN),
    .NUM_CAND (NUM_CAND)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .act         (act),
    .score       (score),
    .busy        (busy),
    .done        (done),
    .best_idx    (best_idx),
    .best_sum    (best_sum),
    .o_dbg_state (o_dbg_state)
`ifdef MATCH_THRESH_EN
    ,
    .min_sum     (min_sum),
    .match_ok    (match_ok)
`endif
  );

  // scoreboard
  int n_total = 0;
  int n_bad   = 0;
  logic [IDX_W+ACC_W-1:0] exp_q[$];
  logic [IDX_W-1:0] m_idx;
  logic [ACC_W-1:0] m_sum;
  logic [7:0] pat [NUM_CAND][WIN_LEN];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        {m_idx, m_sum} = exp_q.pop_front();
        chk("done_best_idx", 32'(best_idx), 32'(m_idx));
        chk("done_best_sum", 32'(best_sum), 32'(m_sum));
      end
    end
  end

  // driver tasks
  task automatic fill_pat(input int mode);
    for (int k = 0; k < NUM_CAND; k++) begin
      for (int j = 0; j < WIN_LEN; j++) begin
        case (mode)
          0:       pat[k][j] = 8'd255;
          1:       pat[k][j] = 8'(10 * k);
          2:       pat[k][j] = (k == 3 || k == 9) ? 8'd125 : ((j % 2 == 0) ? 8'd62 : 8'd63);
          default: pat[k][j] = (k == 6) ? 8'd101 : 8'd100;
        endcase
      end
    end
  endtask

  task automatic run_search(input bit gaps, input bit mid_start, input int abort_k,
                            input logic [IDX_W-1:0] e_idx, input logic [ACC_W-1:0] e_sum);
    if (abort_k < 0) exp_q.push_back({e_idx, e_sum});
    @(negedge clk);
    rst = 1'b1; start = 1'b1; act = 1'b0; score = 8'd0;
    for (int k = 0; k < NUM_CAND; k++) begin
      for (int j = 0; j < WIN_LEN; j++) begin
        @(negedge clk);
        if (k == abort_k && j == 3) begin
          rst = 1'b0; start = 1'b0; act = 1'b1; score = 8'd77;
          @(negedge clk);
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_done", 32'(done), 32'd0);
          chk("abort_best_sum", 32'(best_sum), 32'd0);
          chk("abort_best_idx", 32'(best_idx), 32'd0);
          chk("abort_state", 32'(o_dbg_state), 32'd0);
          act = 1'b0;
          return;
        end
        start = 1'b0; act = 1'b1; score = pat[k][j];
        if (gaps && j != WIN_LEN - 1) begin
          @(negedge clk);
          act = 1'b0; score = 8'd200;
          start = (mid_start && k == 2 && j == 1);
        end
      end
      // COMPARE cycle: this act/score must be dropped
      @(negedge clk);
      start = 1'b0; act = 1'b1; score = 8'd250;
      if (k == NUM_CAND - 1) begin
        chk("lat_compare_done", 32'(done), 32'd0);
        chk("lat_compare_busy", 32'(busy), 32'd1);
      end
    end
    @(negedge clk);
    act = 1'b0; score = 8'd0;
    chk("lat_done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("after_done", 32'(done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("hold_best_sum", 32'(best_sum), 32'(e_sum));
  endtask

  // stimulus
  initial begin
    rst = 1'b0; start = 1'b0; act = 1'b0; score = 8'd0;
`ifdef MATCH_THRESH_EN
    min_sum = 11'd1500;
`endif
    @(negedge clk);
    start = 1'b1; act = 1'b1; score = 8'd255;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_best_sum", 32'(best_sum), 32'd0);
    chk("rst_best_idx", 32'(best_idx), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
`ifdef MATCH_THRESH_EN
    chk("rst_match_ok", 32'(match_ok), 32'd0);
`endif
    start = 1'b0; act = 1'b0;

    fill_pat(0);
    run_search(1'b0, 1'b0, -1, 4'd0, 11'd2040);

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      act = 1'b1; score = 8'd255;
    end
    @(negedge clk);
    act = 1'b0;
    chk("idle_hold_idx", 32'(best_idx), 32'd0);
    chk("idle_hold_sum", 32'(best_sum), 32'd2040);
    chk("idle_state", 32'(o_dbg_state), 32'd0);

    fill_pat(1);
    run_search(1'b0, 1'b0, -1, 4'd15, 11'd1200);
`ifdef MATCH_THRESH_EN
    chk("match_ok_below", 32'(match_ok), 32'd0);
    min_sum = 11'd1200;
    run_search(1'b0, 1'b0, -1, 4'd15, 11'd1200);
    chk("match_ok_equal", 32'(match_ok), 32'd1);
`endif

    fill_pat(2);
    run_search(1'b0, 1'b0, -1, 4'd3, 11'd1000);

    fill_pat(3);
    run_search(1'b1, 1'b1, -1, 4'd6, 11'd808);

    fill_pat(1);
    run_search(1'b0, 1'b0, 5, 4'd0, 11'd0);
    fill_pat(2);
    run_search(1'b0, 1'b0, -1, 4'd3, 11'd1000);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/score_argmax.md
SCORE_ARGMAX -- requirements
Module: score_argmax

Interface
REQ-001 The module SHALL have parameter WIN_LEN, default 8, giving the number of 8-bit scores summed per candidate (power of two, 2..64).
REQ-002 The module SHALL have parameter NUM_CAND, default 16, giving the number of candidates per search (2..256).
REQ-003 The module SHALL have localparams ACC_W = 8 + clog2(WIN_LEN) and IDX_W = clog2(NUM_CAND).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port start, input, 1 bit: a one-cycle pulse that begins a search.
REQ-007 The module SHALL have port act, input, 1 bit: marks score as valid in that cycle.
REQ-008 The module SHALL have port score, input, 8 bits: a per-pixel similarity value (255 minus the absolute difference).
REQ-009 The module SHALL have port busy, output, 1 bit: high while a search is in progress.
REQ-010 The module SHALL have port done, output, 1 bit: a one-cycle pulse when the result is valid.
REQ-011 The module SHALL have port best_idx, output, IDX_W bits: the index of the winning candidate.
REQ-012 The module SHALL have port best_sum, output, ACC_W bits: the winning window sum.

Function
REQ-013 The module SHALL implement a registered FSM with states IDLE, ACCUM, COMPARE and DONE.
REQ-014 In IDLE, start=1 SHALL move the FSM to ACCUM next cycle and clear the accumulator, sample counter, candidate counter, best_idx and best_sum.
REQ-015 In ACCUM, each cycle with act=1 SHALL add score (zero-extended) to the accumulator and increment the sample counter; a cycle with act=0 SHALL hold both.
REQ-016 When act=1 with sample counter = WIN_LEN-1, the FSM SHALL enter COMPARE next cycle and the sample counter SHALL wrap to 0.
REQ-017 In COMPARE, if candidate counter = 0 or accumulator > best_sum, best_sum and best_idx SHALL load the accumulator and candidate counter (strict greater-than, so the lowest index wins ties).
REQ-018 Leaving COMPARE, the accumulator SHALL clear; the FSM SHALL go to DONE if candidate counter = NUM_CAND-1, otherwise increment the candidate counter and return to ACCUM.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE.
REQ-020 best_idx and best_sum SHALL hold their values from DONE until the next accepted start.
REQ-021 Latency: done SHALL assert exactly 2 cycles after the cycle that accepts the last score of the last candidate.
REQ-022 busy SHALL be 1 in ACCUM, COMPARE and DONE, and 0 in IDLE.
REQ-023 start SHALL be ignored outside IDLE; act and score SHALL be ignored outside ACCUM, including act in COMPARE.
REQ-024 The accumulator SHALL never overflow: WIN_LEN*255 fits in ACC_W bits, and no saturation logic is required.

Reset
REQ-025 When rst=0 at a clock edge, the FSM SHALL go to IDLE and busy, done, best_idx, best_sum, the accumulator and all counters SHALL be 0.
REQ-026 Reset asserted mid-search SHALL abort the search with no done pulse; a start in the first cycle after reset release SHALL be accepted.

Configuration
REQ-027 With macro MATCH_THRESH_EN defined, the module SHALL add input min_sum (ACC_W bits) and output match_ok (1 bit).
REQ-028 With MATCH_THRESH_EN defined, match_ok SHALL be set in DONE to (best_sum >= min_sum), held until the next accepted start, cleared at start and reset to 0.
REQ-029 Without MATCH_THRESH_EN, neither port nor the related logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-030 Package sim_match_pkg SHALL hold SCORE_W=8 and the state typedef (IDLE, ACCUM, COMPARE, DONE), shared with the score producer.
REQ-031 The accumulator and sample counter SHALL be a sub-module window_accum, with ports clk, rst, clr, act, score, sum and last.

Verification
REQ-032 Defaults, all scores 255 with act held high, start pulsed -> best_sum=2040, best_idx=0, done high in cycle 2 after the 128th score.
REQ-033 Defaults, candidate k window scores all = 10*k (k=0..15) -> best_idx=15, best_sum=1200.
REQ-034 Candidates 3 and 9 both sum to 1000, all others sum to 500 -> best_idx=3, best_sum=1000.
REQ-035 act toggled 1,0,1,0 with score=100 and a start pulse mid-search -> sums unaffected by idle cycles, second start ignored, a single done pulse.
REQ-036 rst low during candidate 5 ACCUM -> next cycle busy=0, best_sum=0, no done; a new start then completes normally.
REQ-037 With MATCH_THRESH_EN, min_sum=1500, best_sum=1200 -> match_ok=0; min_sum=1200 -> match_ok=1.
